// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C EEPROM target.
// Contents: transaction FSM state encoding, R/W bit values,
// glitch-filter length and the majority-vote helper.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DEV     = 4'd1,
    ST_ACK_DEV = 4'd2,
    ST_AH      = 4'd3,
    ST_ACK_AH  = 4'd4,
    ST_AL      = 4'd5,
    ST_ACK_AL  = 4'd6,
    ST_WR      = 4'd7,
    ST_ACK_WR  = 4'd8,
    ST_RD      = 4'd9,
    ST_MACK    = 4'd10
  } state_e;

  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;

  localparam int FILT_LEN = 3;

  // Two-of-three vote; a single-sample glitch cannot flip the result.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// I2C line conditioning: 2-FF synchronisers, 3-sample majority filter,
// single-cycle SCL edge pulses and START/STOP detection.
// START/STOP are SDA edges seen while filtered SCL is high before and after.
module i2c_bus_cond
  import i2c_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_filt,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0]          scl_sync_r;
  logic [1:0]          sda_sync_r;
  logic [FILT_LEN-1:0] scl_hist_r;
  logic [FILT_LEN-1:0] sda_hist_r;
  logic                scl_f_r;
  logic                sda_f_r;
  logic                scl_rise_r;
  logic                scl_fall_r;
  logic                start_r;
  logic                stop_r;
  logic                scl_maj_s;
  logic                sda_maj_s;

  assign scl_maj_s = maj3(scl_hist_r);
  assign sda_maj_s = maj3(sda_hist_r);

  // Synchronise, filter and derive registered edge / bus-condition pulses.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_hist_r <= {FILT_LEN{1'b1}};
      sda_hist_r <= {FILT_LEN{1'b1}};
      scl_f_r    <= 1'b1;
      sda_f_r    <= 1'b1;
      scl_rise_r <= 1'b0;
      scl_fall_r <= 1'b0;
      start_r    <= 1'b0;
      stop_r     <= 1'b0;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_in};
      sda_sync_r <= {sda_sync_r[0], sda_in};
      scl_hist_r <= {scl_hist_r[FILT_LEN-2:0], scl_sync_r[1]};
      sda_hist_r <= {sda_hist_r[FILT_LEN-2:0], sda_sync_r[1]};
      scl_f_r    <= scl_maj_s;
      sda_f_r    <= sda_maj_s;
      scl_rise_r <= scl_maj_s & ~scl_f_r;
      scl_fall_r <= ~scl_maj_s & scl_f_r;
      start_r    <= scl_f_r & scl_maj_s & sda_f_r & ~sda_maj_s;
      stop_r     <= scl_f_r & scl_maj_s & ~sda_f_r & sda_maj_s;
    end
  end

  assign sda_filt  = sda_f_r;
  assign scl_rise  = scl_rise_r;
  assign scl_fall  = scl_fall_r;
  assign start_det = start_r;
  assign stop_det  = stop_r;

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target modelling a 16-bit-addressed serial EEPROM.
// Supports sequential writes, random reads and current-address reads.
// Optional write protect: define WP_EN to add the wp input; while wp=1
// data bytes are NACKed and dropped, address bytes still update the pointer.
module i2c_eeprom_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         MEM_AW   = 8,
  parameter int         SDA_HOLD = 4
)
(
  input  logic        sys_clk,
  input  logic        sys_rst,
`ifdef WP_EN
  input  logic        wp,
`endif
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        busy,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata
);

  localparam logic [7:0] HOLD_L = 8'(SDA_HOLD);

  state_e      state_r;
  state_e      state_next_s;
  logic [3:0]  bit_cnt_r;
  logic [7:0]  rx_sr_r;
  logic [7:0]  tx_sr_r;
  logic [7:0]  addr_hi_r;
  logic [15:0] ptr_r;
  logic [15:0] ptr_inc_s;
  logic        rw_r;
  logic        ack_ok_r;
  logic        mack_r;
  logic        busy_r;
  logic        sda_oe_r;
  logic [7:0]  hold_cnt_r;
  logic        mem_we_r;
  logic [15:0] mem_addr_r;
  logic [7:0]  mem_wdata_r;
  logic [7:0]  mem_r [0:(2**MEM_AW)-1];

  logic        sda_f_s;
  logic        scl_rise_s;
  logic        scl_fall_s;
  logic        start_s;
  logic        stop_s;
  logic        byte_done_s;
  logic        addr_match_s;
  logic        mem_wr_s;
  logic        drv_s;
  logic        wp_s;

  i2c_bus_cond u_bus_cond (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_filt  (sda_f_s),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .start_det (start_s),
    .stop_det  (stop_s)
  );

`ifdef WP_EN
  logic [1:0] wp_sync_r;

  // Bring the asynchronous write-protect level into the sys_clk domain.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wp_sync_r <= 2'b00;
    end else begin
      wp_sync_r <= {wp_sync_r[0], wp};
    end
  end

  assign wp_s = wp_sync_r[1];
`else
  assign wp_s = 1'b0;
`endif

  assign ptr_inc_s    = ptr_r + 16'd1;
  assign byte_done_s  = (bit_cnt_r == 4'd8);
  assign addr_match_s = (rx_sr_r[7:1] == DEV_ADDR);
  assign mem_wr_s     = (state_r == ST_WR) && scl_fall_s && byte_done_s &&
                        !start_s && !stop_s && !wp_s;

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: bus conditions override everything, otherwise advance on SCL fall.
  always_comb begin
    state_next_s = state_r;
    if (stop_s) begin
      state_next_s = ST_IDLE;
    end else if (start_s) begin
      state_next_s = ST_DEV;
    end else if (scl_fall_s) begin
      case (state_r)
        ST_DEV: begin
          if (byte_done_s) begin
            state_next_s = addr_match_s ? ST_ACK_DEV : ST_IDLE;
          end else begin
            state_next_s = ST_DEV;
          end
        end
        ST_ACK_DEV: state_next_s = (rw_r == I2C_WR) ? ST_AH : ST_RD;
        ST_AH:      state_next_s = byte_done_s ? ST_ACK_AH : ST_AH;
        ST_ACK_AH:  state_next_s = ST_AL;
        ST_AL:      state_next_s = byte_done_s ? ST_ACK_AL : ST_AL;
        ST_ACK_AL:  state_next_s = ST_WR;
        ST_WR:      state_next_s = byte_done_s ? ST_ACK_WR : ST_WR;
        ST_ACK_WR:  state_next_s = ack_ok_r ? ST_WR : ST_IDLE;
        ST_RD:      state_next_s = byte_done_s ? ST_MACK : ST_RD;
        ST_MACK:    state_next_s = mack_r ? ST_IDLE : ST_RD;
        default:    state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Level the target wants on SDA in the current state (1 = pull low).
  always_comb begin
    drv_s = 1'b0;
    case (state_r)
      ST_ACK_DEV, ST_ACK_AH, ST_ACK_AL: drv_s = 1'b1;
      ST_ACK_WR: drv_s = ack_ok_r;
      ST_RD:     drv_s = ~tx_sr_r[7];
      default:   drv_s = 1'b0;
    endcase
  end

  // Shift registers, bit counter, pointer, busy flag and memory-port outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bit_cnt_r   <= 4'd0;
      rx_sr_r     <= 8'h00;
      tx_sr_r     <= 8'h00;
      addr_hi_r   <= 8'h00;
      ptr_r       <= 16'h0000;
      rw_r        <= 1'b0;
      ack_ok_r    <= 1'b0;
      mack_r      <= 1'b0;
      busy_r      <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 16'h0000;
      mem_wdata_r <= 8'h00;
    end else begin
      mem_we_r <= 1'b0;
      if (stop_s || start_s) begin
        bit_cnt_r <= 4'd0;
        ack_ok_r  <= 1'b0;
        if (stop_s) begin
          busy_r <= 1'b0;
        end
      end else if (scl_rise_s) begin
        case (state_r)
          ST_DEV, ST_AH, ST_AL, ST_WR: begin
            rx_sr_r   <= {rx_sr_r[6:0], sda_f_s};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
          ST_RD:   bit_cnt_r <= bit_cnt_r + 4'd1;
          ST_MACK: mack_r    <= sda_f_s;
          default: ;
        endcase
      end else if (scl_fall_s) begin
        case (state_r)
          ST_DEV: begin
            if (byte_done_s) begin
              bit_cnt_r <= 4'd0;
              rw_r      <= rx_sr_r[0];
              if (addr_match_s) begin
                busy_r <= 1'b1;
              end
            end
          end
          ST_AH: begin
            if (byte_done_s) begin
              bit_cnt_r <= 4'd0;
              addr_hi_r <= rx_sr_r;
            end
          end
          ST_AL: begin
            if (byte_done_s) begin
              bit_cnt_r <= 4'd0;
              ptr_r     <= {addr_hi_r, rx_sr_r};
            end
          end
          ST_WR: begin
            if (byte_done_s) begin
              bit_cnt_r <= 4'd0;
              ack_ok_r  <= mem_wr_s;
              if (mem_wr_s) begin
                mem_we_r    <= 1'b1;
                mem_addr_r  <= ptr_r;
                mem_wdata_r <= rx_sr_r;
                ptr_r       <= ptr_inc_s;
              end
            end
          end
          ST_ACK_DEV: begin
            bit_cnt_r <= 4'd0;
            if (rw_r == I2C_RD) begin
              tx_sr_r    <= mem_r[ptr_r[MEM_AW-1:0]];
              mem_addr_r <= ptr_r;
            end
          end
          ST_RD: begin
            if (byte_done_s) begin
              bit_cnt_r <= 4'd0;
            end else begin
              tx_sr_r <= {tx_sr_r[6:0], 1'b0};
            end
          end
          ST_MACK: begin
            bit_cnt_r <= 4'd0;
            ptr_r     <= ptr_inc_s;
            if (!mack_r) begin
              tx_sr_r    <= mem_r[ptr_inc_s[MEM_AW-1:0]];
              mem_addr_r <= ptr_inc_s;
            end
          end
          default: bit_cnt_r <= 4'd0;
        endcase
      end
    end
  end

  // Byte array: written once per accepted data byte, never reset.
  always_ff @(posedge sys_clk) begin
    if (mem_wr_s) begin
      mem_r[ptr_r[MEM_AW-1:0]] <= rx_sr_r;
    end
  end

  // SDA driver: apply the wanted level SDA_HOLD cycles after SCL falls; release on START/STOP.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sda_oe_r   <= 1'b0;
      hold_cnt_r <= 8'd0;
    end else if (start_s || stop_s) begin
      sda_oe_r   <= 1'b0;
      hold_cnt_r <= 8'd0;
    end else if (scl_fall_s) begin
      hold_cnt_r <= HOLD_L;
    end else if (hold_cnt_r != 8'd0) begin
      hold_cnt_r <= hold_cnt_r - 8'd1;
      if (hold_cnt_r == 8'd1) begin
        sda_oe_r <= drv_s;
      end
    end
  end

  assign sda_oe    = sda_oe_r;
  assign busy      = busy_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: doc/i2c_eeprom_target.md
Name: i2c_eeprom_target

Overview:
- I2C target (responder) modelling a 16-bit-addressed serial EEPROM. It is the far end of our I2C master / read-write data generator.
- Oversamples SCL/SDA on sys_clk, detects START/STOP, matches the device address, and accepts a 2-byte word address.
- Serves sequential writes, random reads and current-address reads from an internal byte array.
- Used in simulation benches and as an on-chip loopback target for the I2C master.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address (write byte 0xA0, read byte 0xA1).
- MEM_AW, 8, internal array address width; depth is 2^MEM_AW bytes.
- SDA_HOLD, 4, sys_clk cycles after a detected SCL fall before sda_oe may change.

Ports:
- sys_clk  in  1  system clock, at least 8x the SCL rate.
- sys_rst  in  1  asynchronous active-high reset.
- scl_in  in  1  raw SCL pin level.
- sda_in  in  1  raw SDA pin level.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- busy  out  1  high from an addressed START until STOP.
- mem_we  out  1  one-cycle pulse per byte committed to the array.
- mem_addr  out  16  word address of the last committed or read byte.
- mem_wdata  out  8  data committed on mem_we.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (sys_clk, sys_rst).
  - All outputs 0 and state IDLE.
  - Address pointer 0; synchronisers preset to 1.
  - Array contents are neither reset nor initialised.
- Input conditioning: 2-FF synchroniser on each line, then 3-sample majority filter.
  - scl_rise / scl_fall: single-cycle pulses on filtered edges.
- Bus conditions (filtered SDA edge while filtered SCL is high):
  - START: SDA falls. STOP: SDA rises.
  - START or STOP is accepted in any state and aborts the current byte.
  - STOP → IDLE, sda_oe=0, busy=0.
  - START (including repeated) → DEV.
- Bit timing:
  - Sample SDA on scl_rise, MSB first.
  - sda_oe updates SDA_HOLD cycles after scl_fall.
- FSM states: IDLE, DEV, ACK_DEV, AH, ACK_AH, AL, ACK_AL, WR, ACK_WR, RD, MACK.
  - DEV: 8 bits received.
    - Address mismatch: no ACK, go IDLE (busy stays 0).
    - Match: busy=1, ACK (sda_oe=1 for the 9th clock).
    - R/W=0 → AH. R/W=1 → RD.
  - AH / AL: receive pointer high / low byte, ACK each.
    - After ACK_AL → WR. The pointer is loaded only when AL completes.
  - WR: receive byte, then ACK.
    - On the ACK scl_fall: array[ptr[MEM_AW-1:0]] <= byte; mem_we pulses one cycle with mem_addr=ptr, mem_wdata=byte; ptr increments.
  - RD: drive array[ptr] MSB first. sda_oe = ~bit, so a 1 releases the line.
    - MACK: sample the master's bit. 0 (ACK) → ptr++, next byte → RD. 1 (NACK) → ptr++, release SDA, wait for STOP or START.
- Pointer arithmetic: 16-bit register, increments modulo 2^16.
  - The array is indexed by the low MEM_AW bits, so it aliases and wraps 0xFF → 0x00 at default.
- Current-address read: DEV with R/W=1 straight after START reads from the retained pointer.
- A partial byte interrupted by START/STOP is discarded; no write occurs.

Optional Feature:
- Macro WP_EN.
- When defined: an extra input port wp (1 bit), synchronised with 2 FFs.
  - While wp=1, data bytes in WR are NACKed and not written, and mem_we stays 0.
  - Address bytes are still ACKed and the pointer is still updated.
- When undefined: no wp port, all writes are accepted.

Decomposition:
- Package i2c_pkg:
  - FSM state enum.
  - I2C_RD / I2C_WR bit constants.
  - Filter length constant (3).
- One sub-module: i2c_bus_cond.
  - Synchronisers, majority filter, scl_rise/scl_fall pulses, start_det/stop_det pulses.
- Array, FSM and pointer stay in the top module.

Test Plan:
- Write: START, 0xA0, 0x00, 0x5A, 0xA5, STOP → four ACKs; one mem_we with mem_addr=0x005A, mem_wdata=0xA5; busy falls at STOP.
- Random read: START, 0xA0, 0x00, 0x5A, Sr, 0xA1, read one byte, master NACK, STOP → 0xA5 returned; sda_oe=0 after NACK.
- Sequential wrap: write 0x11, 0x22 starting at 0x00FF, then read 2 from 0x00FF → mem_addr 0x00FF then 0x0100; reads return 0x11, 0x22; array index 0xFF then 0x00.
- Address mismatch: START, 0xA2, ... → no ACK on any bit; busy=0; sda_oe never asserted until the next START.
- Abort: assert sys_rst mid-WR byte (bit 4) → sda_oe=0 and busy=0 immediately; the next valid write transaction completes normally. A separate STOP mid-byte → no mem_we.
- WP_EN: wp=1, write 0x77 to 0x0010 → data byte NACKed, no mem_we; read back returns the previously written value.
